// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, reads a combinational instruction
// memory and buffers fetched words in a small FIFO for the decode stage.
module fetch_sequencer #(
  parameter int ADDR_W     = 32,
  parameter int RESET_PC   = 0,
  parameter int PROG_WORDS = 7,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_instruction,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [31:0]       if_instruction,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              busy,
  output logic              halted
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] RESET_PC_L = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] PROG_LIMIT = ADDR_W'(PROG_WORDS);
  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(32'd4);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
  localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  ZERO_CNT   = {CNT_W{1'b0}};
  localparam logic [PTR_W-1:0]  ZERO_PTR   = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0]  ONE_PTR    = PTR_W'(1'b1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] pc_next_s;
  logic [PTR_W-1:0]  head_r;
  logic [PTR_W-1:0]  tail_r;
  logic [CNT_W-1:0]  count_r;
  logic [31:0]       inst_mem_r [FIFO_DEPTH];
  logic [ADDR_W-1:0] pc_mem_r   [FIFO_DEPTH];

  logic empty_s;
  logic full_s;
  logic in_range_s;
  logic pop_s;
  logic push_s;
  logic flush_s;
  logic drained_s;

  // Handshake and FIFO control decode; redirect outranks any push.
  always_comb begin
    empty_s    = (count_r == ZERO_CNT);
    full_s     = (count_r == FULL_CNT);
    in_range_s = ({2'b00, pc_r[ADDR_W-1:2]} < PROG_LIMIT);
    pop_s      = !empty_s && if_ready;
    flush_s    = redirect && (state_r != ST_IDLE);
    push_s     = (state_r == ST_RUN) && !redirect && in_range_s && (!full_s || pop_s);
    drained_s  = ((count_r - CNT_W'(pop_s)) == ZERO_CNT);
  end

  // Next-state and next-PC logic.
  always_comb begin
    state_next_s = state_r;
    pc_next_s    = pc_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_next_s = ST_RUN;
        else       state_next_s = ST_IDLE;
      end
      ST_RUN: begin
        if (redirect)         state_next_s = ST_RUN;
        else if (!in_range_s) state_next_s = ST_DRAIN;
        else                  state_next_s = ST_RUN;
      end
      ST_DRAIN: begin
        if (redirect)       state_next_s = ST_RUN;
        else if (drained_s) state_next_s = ST_HALT;
        else                state_next_s = ST_DRAIN;
      end
      ST_HALT: begin
        if (redirect) state_next_s = ST_RUN;
        else          state_next_s = ST_HALT;
      end
      default: state_next_s = ST_IDLE;
    endcase
    if (flush_s)     pc_next_s = redirect_pc & ALIGN_MASK;
    else if (push_s) pc_next_s = pc_r + PC_STEP;
    else             pc_next_s = pc_r;
  end

  // State and PC registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      pc_r    <= RESET_PC_L;
    end else begin
      state_r <= state_next_s;
      pc_r    <= pc_next_s;
    end
  end

  // Fetch buffer storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r  <= ZERO_PTR;
      tail_r  <= ZERO_PTR;
      count_r <= ZERO_CNT;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        inst_mem_r[i] <= 32'd0;
        pc_mem_r[i]   <= {ADDR_W{1'b0}};
      end
    end else if (flush_s) begin
      head_r  <= ZERO_PTR;
      tail_r  <= ZERO_PTR;
      count_r <= ZERO_CNT;
    end else begin
      if (push_s) begin
        inst_mem_r[tail_r] <= imem_instruction;
        pc_mem_r[tail_r]   <= pc_r;
        tail_r             <= tail_r + ONE_PTR;
      end
      if (pop_s) begin
        head_r <= head_r + ONE_PTR;
      end
      count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
    end
  end

  // Outputs decoded from registers; head fields are zeroed while empty.
  always_comb begin
    imem_addr = pc_r;
    if_valid  = !empty_s;
    busy      = (state_r == ST_RUN) || (state_r == ST_DRAIN);
    halted    = (state_r == ST_HALT);
    if (empty_s) begin
      if_instruction = 32'd0;
      if_pc          = {ADDR_W{1'b0}};
    end else begin
      if_instruction = inst_mem_r[head_r];
      if_pc          = pc_mem_r[head_r];
    end
  end

endmodule
